// File: rtl/shift_reg_chain_pkg.sv
// Shared types and width helpers for the 74HC595 daisy-chain driver.
package shift_reg_chain_pkg;

    localparam int unsigned REG_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH_LO = 3'd3,
        LATCH_HI = 3'd4
    } state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_chain_if.sv
// Controller/board-side signal bundle for shift_reg_chain.
interface shift_reg_chain_if
    import shift_reg_chain_pkg::*;
#(
    parameter int unsigned N_REGS = 3
);
    localparam int unsigned W = REG_BITS * N_REGS;

    logic [W-1:0] i_Data;
    logic         i_Enable;
    logic         o_Ready;
    logic         o_SRCLK;
    logic         o_SER;
    logic         o_RCLK;
    logic         i_QH;
    logic [W-1:0] o_RbData;
    logic         o_RbErr;

    modport master (
        output i_Data, i_Enable, i_QH,
        input  o_Ready, o_SRCLK, o_SER, o_RCLK, o_RbData, o_RbErr
    );

    modport slave (
        input  i_Data, i_Enable, i_QH,
        output o_Ready, o_SRCLK, o_SER, o_RCLK, o_RbData, o_RbErr
    );

endinterface

// File: rtl/shift_reg_chain_clk_div_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV enabled cycles, synchronous clear.
module clk_div_tick
    import shift_reg_chain_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c_o
);
    localparam int unsigned      CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/shift_reg_chain.sv
// Serialises a W-bit frame into a chain of 74HC595s (SER/SRCLK/RCLK).
// Optional readback of the previous chain contents via i_QH: define SHIFTREG_READBACK_EN.
module shift_reg_chain
    import shift_reg_chain_pkg::*;
#(
    parameter int unsigned N_REGS    = 3,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    shift_reg_chain_if.slave   bus
);
    localparam int unsigned W     = REG_BITS * N_REGS;
    localparam int unsigned BIT_W = cnt_width(W);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic             ready_q, ready_d;
    logic             srclk_q, srclk_d;
    logic             ser_q, ser_d;
    logic             rclk_q, rclk_d;
    logic             ser_bit_c;
    logic             tick_c;
    logic             accept_c;
    logic             last_bit_c;

    assign accept_c   = (state_q == IDLE) && bus.i_Enable && ready_q;
    assign last_bit_c = (bit_q == BIT_W'(W - 1));

    // Every non-idle state lasts exactly one divider period.
    clk_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .en_i     (state_q != IDLE),
        .clr_i    (state_q == IDLE),
        .tick_c_o (tick_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept_c) state_d = SHIFT_LO;
            SHIFT_LO: if (tick_c)   state_d = SHIFT_HI;
            SHIFT_HI: if (tick_c)   state_d = last_bit_c ? LATCH_LO : SHIFT_LO;
            LATCH_LO: if (tick_c)   state_d = LATCH_HI;
            LATCH_HI: if (tick_c)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so pins change on the transition edge.
    always_comb begin
        bit_d    = bit_q;
        shadow_d = shadow_q;
        if (accept_c) begin
            bit_d    = '0;
            shadow_d = bus.i_Data;
        end else if ((state_q == SHIFT_HI) && tick_c) begin
            bit_d    = bit_q + BIT_W'(1);
            shadow_d = MSB_FIRST ? {shadow_q[W-2:0], 1'b0} : {1'b0, shadow_q[W-1:1]};
        end
        ser_bit_c = MSB_FIRST ? shadow_d[W-1] : shadow_d[0];
        ready_d   = (state_d == IDLE);
        srclk_d   = (state_d == SHIFT_HI);
        rclk_d    = (state_d == LATCH_HI);
        ser_d     = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && ser_bit_c;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_q    <= '0;
            shadow_q <= '0;
            ready_q  <= 1'b1;
            srclk_q  <= 1'b0;
            ser_q    <= 1'b0;
            rclk_q   <= 1'b0;
        end else begin
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            ready_q  <= ready_d;
            srclk_q  <= srclk_d;
            ser_q    <= ser_d;
            rclk_q   <= rclk_d;
        end
    end

    assign bus.o_Ready = ready_q;
    assign bus.o_SRCLK = srclk_q;
    assign bus.o_SER   = ser_q;
    assign bus.o_RCLK  = rclk_q;

`ifdef SHIFTREG_READBACK_EN
    logic         qh_s1_q, qh_s2_q;
    logic         rise_q, rise2_q;
    logic         have_prev_q;
    logic         rb_err_q;
    logic [W-1:0] rb_shift_q, rb_data_q, frame_q, prev_frame_q;
    logic         rise_c;
    logic         rclk_fall_c;

    assign rise_c      = (state_d == SHIFT_HI) && (state_q != SHIFT_HI);
    assign rclk_fall_c = (state_q == LATCH_HI) && (state_d == IDLE);

    // Two cycles after each SRCLK rise the synchroniser shows QH as it was just before that rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            qh_s1_q      <= 1'b0;
            qh_s2_q      <= 1'b0;
            rise_q       <= 1'b0;
            rise2_q      <= 1'b0;
            have_prev_q  <= 1'b0;
            rb_err_q     <= 1'b0;
            rb_shift_q   <= '0;
            rb_data_q    <= '0;
            frame_q      <= '0;
            prev_frame_q <= '0;
        end else begin
            qh_s1_q <= bus.i_QH;
            qh_s2_q <= qh_s1_q;
            rise_q  <= rise_c;
            rise2_q <= rise_q;
            if (accept_c) begin
                frame_q <= bus.i_Data;
            end
            if (rise2_q) begin
                rb_shift_q <= MSB_FIRST ? {rb_shift_q[W-2:0], qh_s2_q}
                                        : {qh_s2_q, rb_shift_q[W-1:1]};
            end
            if (rclk_fall_c) begin
                rb_data_q    <= rb_shift_q;
                rb_err_q     <= have_prev_q && (rb_shift_q != prev_frame_q);
                prev_frame_q <= frame_q;
                have_prev_q  <= 1'b1;
            end
        end
    end

    assign bus.o_RbData = rb_data_q;
    assign bus.o_RbErr  = rb_err_q;
`else
    logic unused_qh;
    assign unused_qh    = bus.i_QH;
    assign bus.o_RbData = '0;
    assign bus.o_RbErr  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_chain.sv
// Bench for shift_reg_chain: two instances (DIV=4 MSB-first, DIV=1 LSB-first) driving 595 chain models.
`timescale 1ns/1ps
module tb_shift_reg_chain;
    localparam int unsigned W     = 24;
    localparam int          LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    shift_reg_chain_if #(.N_REGS(3)) bus_a ();
    shift_reg_chain_if #(.N_REGS(3)) bus_b ();

    shift_reg_chain #(.N_REGS(3), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    shift_reg_chain #(.N_REGS(3), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.slave)
    );

    // Board model: chain[0] is QA of the first register, chain[W-1] is QH of the last.
    logic [W-1:0] chain_a = '0, store_a = '0, chain_b = '0, store_b = '0;
    logic         qh_stuck = 1'b0;
    int           rclk_a = 0, rclk_b = 0;
    logic         ser_a[$];
    logic         ser_b[$];

    always @(posedge bus_a.o_SRCLK) begin
        ser_a.push_back(bus_a.o_SER);
        chain_a <= {chain_a[W-2:0], bus_a.o_SER};
    end
    always @(posedge bus_a.o_RCLK) begin
        store_a <= chain_a;
        rclk_a++;
    end
    always @(posedge bus_b.o_SRCLK) begin
        ser_b.push_back(bus_b.o_SER);
        chain_b <= {chain_b[W-2:0], bus_b.o_SER};
    end
    always @(posedge bus_b.o_RCLK) begin
        store_b <= chain_b;
        rclk_b++;
    end

    assign bus_a.i_QH = qh_stuck ? 1'b0 : chain_a[W-1];
    assign bus_b.i_QH = chain_b[W-1];

    // Pin-level rules: SER steady while SRCLK high, RCLK never high together with SRCLK.
    int   viol_a = 0, viol_b = 0;
    logic pser_a = 1'b0, pser_b = 1'b0;
    always @(negedge clk) begin
        if (bus_a.o_SRCLK === 1'b1 && (bus_a.o_SER !== pser_a || bus_a.o_RCLK === 1'b1)) viol_a++;
        if (bus_b.o_SRCLK === 1'b1 && (bus_b.o_SER !== pser_b || bus_b.o_RCLK === 1'b1)) viol_b++;
        pser_a = bus_a.o_SER;
        pser_b = bus_b.o_SER;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Serial bits as a word: i-th bit sent lands at data[W-1-i] (a) or data[i] (b).
    function automatic logic [W-1:0] seq_a();
        logic [W-1:0] s = '0;
        for (int i = 0; i < ser_a.size() && i < W; i++) s[W-1-i] = ser_a[i];
        return s;
    endfunction
    function automatic logic [W-1:0] seq_b();
        logic [W-1:0] s = '0;
        for (int i = 0; i < ser_b.size() && i < W; i++) s[i] = ser_b[i];
        return s;
    endfunction

    task automatic send_a(input logic [W-1:0] data, input logic [W-1:0] after, input logic hold);
        ser_a.delete();
        bus_a.i_Data   = data;
        bus_a.i_Enable = 1'b1;
        @(negedge clk);
        bus_a.i_Enable = hold;
        bus_a.i_Data   = after;
    endtask

    task automatic send_b(input logic [W-1:0] data, input logic [W-1:0] after);
        ser_b.delete();
        bus_b.i_Data   = data;
        bus_b.i_Enable = 1'b1;
        @(negedge clk);
        bus_b.i_Enable = 1'b0;
        bus_b.i_Data   = after;
    endtask

    // Counts busy samples; optionally pulses i_Enable for one cycle at busy sample pulse_at.
    task automatic wait_ready_a(input int pulse_at, output int cyc);
        cyc = 0;
        while (bus_a.o_Ready !== 1'b1 && cyc < LIMIT) begin
            cyc++;
            if (cyc == pulse_at) begin
                bus_a.i_Enable = 1'b1;
                bus_a.i_Data   = W'($urandom);
            end else if (cyc == pulse_at + 1) begin
                bus_a.i_Enable = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready_b(output int cyc);
        cyc = 0;
        while (bus_b.o_Ready !== 1'b1 && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int           cyc;
        int           n;
        int           r0;
        logic [W-1:0] d;
        logic [W-1:0] snap;

        bus_a.i_Data = '0; bus_a.i_Enable = 1'b0;
        bus_b.i_Data = '0; bus_b.i_Enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_a",  64'(bus_a.o_Ready),  64'(1));
        check("rst_srclk_a",  64'(bus_a.o_SRCLK),  64'(0));
        check("rst_ser_a",    64'(bus_a.o_SER),    64'(0));
        check("rst_rclk_a",   64'(bus_a.o_RCLK),   64'(0));
        check("rst_rbdata_a", 64'(bus_a.o_RbData), 64'(0));
        check("rst_rberr_a",  64'(bus_a.o_RbErr),  64'(0));
        check("rst_ready_b",  64'(bus_b.o_Ready),  64'(1));
        check("rst_srclk_b",  64'(bus_b.o_SRCLK),  64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single frame, MSB first, with an ignored enable pulse mid-frame.
        r0 = rclk_a;
        send_a(24'hA5C30F, 24'h5A3C0F, 1'b0);
        wait_ready_a(100, cyc);
        check("t1_busy",      64'(cyc),            64'(200));
        check("t1_rises",     64'(ser_a.size()),   64'(W));
        check("t1_ser_order", 64'(seq_a()),        64'(24'hA5C30F));
        check("t1_rclk",      64'(rclk_a - r0),    64'(1));
        check("t1_store",     64'(store_a),        64'(24'hA5C30F));
        @(negedge clk);
        check("t1_ready_idle", 64'(bus_a.o_Ready), 64'(1));

        // LSB first, single set bit, CLK_DIV=1.
        r0 = rclk_b;
        send_b(24'h000001, 24'hFFFFFF);
        wait_ready_b(cyc);
        check("t2_busy",      64'(cyc),           64'(50));
        check("t2_first_ser", 64'(ser_b[0]),      64'(1));
        check("t2_rises",     64'(ser_b.size()),  64'(W));
        check("t2_ser_order", 64'(seq_b()),       64'(24'h000001));
        check("t2_store",     64'(store_b),       64'(24'h800000));
        check("t2_rclk",      64'(rclk_b - r0),   64'(1));

        // Back-to-back frames with enable held; data changes while busy.
        r0 = rclk_a;
        send_a(24'h111111, 24'h222222, 1'b1);
        wait_ready_a(-1, cyc);
        check("t3_busy1",  64'(cyc),     64'(200));
        check("t3_store1", 64'(store_a), 64'(24'h111111));
        @(negedge clk);
        check("t3_accept_next", 64'(bus_a.o_Ready), 64'(0));
        bus_a.i_Enable = 1'b0;
        ser_a.delete();
        wait_ready_a(-1, cyc);
        check("t3_busy2",  64'(cyc),          64'(200));
        check("t3_store2", 64'(store_a),      64'(24'h222222));
        check("t3_rises2", 64'(ser_a.size()), 64'(W));
        check("t3_rclk",   64'(rclk_a - r0),  64'(2));

        // Reset at bit 10 of a frame.
        r0 = rclk_a;
        send_a(24'h0F0F0F, W'($urandom), 1'b0);
        n = 0;
        while (ser_a.size() < 10 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_bit10", 64'(ser_a.size()), 64'(10));
        #1 rst = 1'b1;
        #1;
        check("t4_ready", 64'(bus_a.o_Ready), 64'(1));
        check("t4_srclk", 64'(bus_a.o_SRCLK), 64'(0));
        check("t4_ser",   64'(bus_a.o_SER),   64'(0));
        check("t4_rclk",  64'(bus_a.o_RCLK),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_no_latch", 64'(rclk_a - r0), 64'(0));
        check("t4_store",    64'(store_a),     64'(24'h222222));
        check("t4_idle",     64'(bus_a.o_Ready), 64'(1));

`ifdef SHIFTREG_READBACK_EN
        // Readback through the chain model's QH.
        snap = chain_a;
        send_a(24'h123456, W'($urandom), 1'b0);
        wait_ready_a(-1, cyc);
        check("t6_busy1",   64'(cyc),            64'(200));
        check("t6_rb1",     64'(bus_a.o_RbData), 64'(snap));
        check("t6_err1",    64'(bus_a.o_RbErr),  64'(0));
        send_a(24'hABCDEF, W'($urandom), 1'b0);
        wait_ready_a(-1, cyc);
        check("t6_rb2",     64'(bus_a.o_RbData), 64'(24'h123456));
        check("t6_err2",    64'(bus_a.o_RbErr),  64'(0));
        qh_stuck = 1'b1;
        send_a(24'h5A5A5A, W'($urandom), 1'b0);
        wait_ready_a(-1, cyc);
        check("t6_rb_stuck",  64'(bus_a.o_RbData), 64'(0));
        check("t6_err_stuck", 64'(bus_a.o_RbErr),  64'(1));
        qh_stuck = 1'b0;
`else
        snap = '0;
        send_a(24'h123456, W'($urandom), 1'b0);
        wait_ready_a(-1, cyc);
        check("t6_rb_tied",  64'(bus_a.o_RbData), 64'(snap));
        check("t6_err_tied", 64'(bus_a.o_RbErr),  64'(0));
        check("t6_store",    64'(store_a),        64'(24'h123456));
`endif

        // Random frames at CLK_DIV=1, LSB first.
        for (int k = 0; k < 100; k++) begin
            d = W'($urandom);
            send_b(d, W'($urandom));
            wait_ready_b(cyc);
            check("t5_busy",  64'(cyc),          64'(50));
            check("t5_store", 64'(store_b),      64'(rev(d)));
            check("t5_rises", 64'(ser_b.size()), 64'(W));
        end

        check("pin_rules_a", 64'(viol_a), 64'(0));
        check("pin_rules_b", 64'(viol_b), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
